// File: rtl/mul_wb_scheduler_pkg.sv
// Shared definitions for the multiply pipeline controller and ROB writeback arbiter.
package mul_wb_scheduler_pkg;

    localparam int WORD_SIZE_DEF       = 32;
    localparam int ROB_ENTRY_WIDTH_DEF = 6;
    localparam int MUL_STAGES_DEF      = 5;
    localparam int STARVE_LIMIT_DEF    = 3;

    localparam logic WB_SRC_ALU = 1'b0;
    localparam logic WB_SRC_MUL = 1'b1;

    typedef enum logic {
        ALU_PRIO = 1'b0,
        MUL_PRIO = 1'b1
    } wb_prio_e;

    // Saturating 4-bit increment; the counter never exceeds lim.
    function automatic logic [3:0] sat_inc4(input logic [3:0] v, input logic [3:0] lim);
        return (v >= lim) ? lim : v + 4'd1;
    endfunction

endpackage

// File: rtl/mul_wb_scheduler_stall.sv
// Backward stall chain for the M stage registers: a stalled stage only holds the
// stage behind it when it is itself occupied, so bubbles collapse.
module mul_wb_scheduler_stall #(
    parameter int MUL_STAGES = 5
) (
    input  logic [MUL_STAGES-1:0] m_valid_i,
    input  logic                  m5_stall_i,
    output logic [MUL_STAGES-1:0] m_stall_o,
    output logic                  issue_stall_o
);

    assign m_stall_o[MUL_STAGES-1] = m5_stall_i;

    for (genvar k = MUL_STAGES - 2; k >= 0; k--) begin : g_chain
        assign m_stall_o[k] = m_stall_o[k+1] && m_valid_i[k+1];
    end

    assign issue_stall_o = m_stall_o[0] && m_valid_i[0];

endmodule

// File: rtl/mul_wb_scheduler.sv
// Multiply pipeline stall/kill controller and ALU/MUL arbiter for the single ROB
// write port, with a starvation counter that temporarily hands priority to MUL.
//
// state    | meaning
// ALU_PRIO | ALU wins a writeback conflict (default)
// MUL_PRIO | MUL wins a conflict; left on the first MUL grant or on flush
module mul_wb_scheduler
    import mul_wb_scheduler_pkg::*;
#(
    parameter int WORD_SIZE       = WORD_SIZE_DEF,
    parameter int ROB_ENTRY_WIDTH = ROB_ENTRY_WIDTH_DEF,
    parameter int MUL_STAGES      = MUL_STAGES_DEF,
    parameter int STARVE_LIMIT    = STARVE_LIMIT_DEF
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic [MUL_STAGES-1:0]      m_valid,
    input  logic [ROB_ENTRY_WIDTH-1:0] mul_rob_id,
    input  logic [WORD_SIZE-1:0]       mul_result,
    input  logic                       alu_wb_valid,
    input  logic [ROB_ENTRY_WIDTH-1:0] alu_wb_rob_id,
    input  logic [WORD_SIZE-1:0]       alu_wb_value,
    output logic [MUL_STAGES-1:0]      m_stall,
    output logic                       mul_issue_stall,
    output logic                       alu_stall,
    output logic                       m_kill,
    output logic                       rob_wr_en,
    output logic [ROB_ENTRY_WIDTH-1:0] rob_wr_id,
    output logic [WORD_SIZE-1:0]       rob_wr_value,
    output logic                       rob_wr_src,
    output logic [2:0]                 mul_inflight
);

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_LIMIT);

    logic mul_req;
    logic alu_req;
    logic mul_grant;
    logic alu_grant;
    logic m5_stall;

    wb_prio_e   state_q, state_d;
    logic [3:0] starve_cnt_q, starve_cnt_d;

    logic                       rob_wr_en_q, rob_wr_en_d;
    logic [ROB_ENTRY_WIDTH-1:0] rob_wr_id_q, rob_wr_id_d;
    logic [WORD_SIZE-1:0]       rob_wr_value_q, rob_wr_value_d;
    logic                       rob_wr_src_q, rob_wr_src_d;

    // Flush masks the MUL request, which also zeroes the whole stall chain.
    always_comb begin
        mul_req   = m_valid[MUL_STAGES-1] && !flush;
        alu_req   = alu_wb_valid;
        mul_grant = mul_req && (!alu_req || (state_q == MUL_PRIO));
        alu_grant = alu_req && !mul_grant;
        m5_stall  = mul_req && !mul_grant;
    end

    assign alu_stall = alu_req && !alu_grant;
    assign m_kill    = flush;

    mul_wb_scheduler_stall #(
        .MUL_STAGES (MUL_STAGES)
    ) u_stall (
        .m_valid_i     (m_valid),
        .m5_stall_i    (m5_stall),
        .m_stall_o     (m_stall),
        .issue_stall_o (mul_issue_stall)
    );

    always_comb begin
        mul_inflight = 3'd0;
        for (int i = 0; i < MUL_STAGES; i++) begin
            mul_inflight = mul_inflight + 3'(m_valid[i]);
        end
    end

    always_comb begin
        starve_cnt_d = starve_cnt_q;
        state_d      = state_q;

        if (flush || mul_grant) begin
            starve_cnt_d = 4'd0;
        end else if (mul_req) begin
            starve_cnt_d = sat_inc4(starve_cnt_q, STARVE_LIM);
        end

        case (state_q)
            ALU_PRIO: begin
                if (!flush && m5_stall && (starve_cnt_d == STARVE_LIM)) begin
                    state_d = MUL_PRIO;
                end
            end
            MUL_PRIO: begin
                if (flush || mul_grant) begin
                    state_d = ALU_PRIO;
                end
            end
            default: state_d = ALU_PRIO;
        endcase
    end

    // Data fields hold between grants; only the strobe marks a new write.
    always_comb begin
        rob_wr_en_d    = mul_grant || alu_grant;
        rob_wr_id_d    = rob_wr_id_q;
        rob_wr_value_d = rob_wr_value_q;
        rob_wr_src_d   = rob_wr_src_q;
        if (mul_grant) begin
            rob_wr_id_d    = mul_rob_id;
            rob_wr_value_d = mul_result;
            rob_wr_src_d   = WB_SRC_MUL;
        end else if (alu_grant) begin
            rob_wr_id_d    = alu_wb_rob_id;
            rob_wr_value_d = alu_wb_value;
            rob_wr_src_d   = WB_SRC_ALU;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= ALU_PRIO;
            starve_cnt_q   <= 4'd0;
            rob_wr_en_q    <= 1'b0;
            rob_wr_id_q    <= '0;
            rob_wr_value_q <= '0;
            rob_wr_src_q   <= WB_SRC_ALU;
        end else begin
            state_q        <= state_d;
            starve_cnt_q   <= starve_cnt_d;
            rob_wr_en_q    <= rob_wr_en_d;
            rob_wr_id_q    <= rob_wr_id_d;
            rob_wr_value_q <= rob_wr_value_d;
            rob_wr_src_q   <= rob_wr_src_d;
        end
    end

    assign rob_wr_en    = rob_wr_en_q;
    assign rob_wr_id    = rob_wr_id_q;
    assign rob_wr_value = rob_wr_value_q;
    assign rob_wr_src   = rob_wr_src_q;

endmodule

// File: tb/tb_mul_wb_scheduler.sv
// Directed and randomized checks of mul_wb_scheduler against a behavioural model.
module tb_mul_wb_scheduler;

    localparam int W   = 32;
    localparam int R   = 6;
    localparam int N   = 5;
    localparam int LIM = 3;

    logic         clk = 1'b0;
    logic         reset;
    logic         flush;
    logic [N-1:0] m_valid;
    logic [R-1:0] mul_rob_id;
    logic [W-1:0] mul_result;
    logic         alu_wb_valid;
    logic [R-1:0] alu_wb_rob_id;
    logic [W-1:0] alu_wb_value;
    logic [N-1:0] m_stall;
    logic         mul_issue_stall;
    logic         alu_stall;
    logic         m_kill;
    logic         rob_wr_en;
    logic [R-1:0] rob_wr_id;
    logic [W-1:0] rob_wr_value;
    logic         rob_wr_src;
    logic [2:0]   mul_inflight;

    int total = 0;
    int fails = 0;

    // Model state: consecutive MUL losses and whether MUL currently has priority.
    int           losses;
    bit           mul_prio;
    bit           exp_en;
    bit           exp_src;
    logic [R-1:0] exp_id;
    logic [W-1:0] exp_val;

    mul_wb_scheduler #(
        .WORD_SIZE       (W),
        .ROB_ENTRY_WIDTH (R),
        .MUL_STAGES      (N),
        .STARVE_LIMIT    (LIM)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .flush           (flush),
        .m_valid         (m_valid),
        .mul_rob_id      (mul_rob_id),
        .mul_result      (mul_result),
        .alu_wb_valid    (alu_wb_valid),
        .alu_wb_rob_id   (alu_wb_rob_id),
        .alu_wb_value    (alu_wb_value),
        .m_stall         (m_stall),
        .mul_issue_stall (mul_issue_stall),
        .alu_stall       (alu_stall),
        .m_kill          (m_kill),
        .rob_wr_en       (rob_wr_en),
        .rob_wr_id       (rob_wr_id),
        .rob_wr_value    (rob_wr_value),
        .rob_wr_src      (rob_wr_src),
        .mul_inflight    (mul_inflight)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit fl, input logic [N-1:0] mv, input bit av,
                         input logic [R-1:0] aid, input logic [W-1:0] aval,
                         input logic [R-1:0] mid, input logic [W-1:0] mres);
        flush         = fl;
        m_valid       = mv;
        alu_wb_valid  = av;
        alu_wb_rob_id = aid;
        alu_wb_value  = aval;
        mul_rob_id    = mid;
        mul_result    = mres;
    endtask

    task automatic model_reset();
        losses   = 0;
        mul_prio = 0;
        exp_en   = 0;
    endtask

    // Checks combinational outputs for the driven inputs, clocks once, then
    // checks the registered writeback against the model's prediction.
    task automatic step();
        bit           mreq, areq, mg, ag, above;
        logic [N-1:0] es;
        #1;
        mreq = m_valid[N-1] && !flush;
        areq = alu_wb_valid;
        mg   = mreq && (!areq || mul_prio);
        ag   = areq && !mg;
        es[N-1] = mreq && !mg;
        for (int k = N - 2; k >= 0; k--) begin
            above = 1;
            for (int j = k + 1; j < N; j++) above = above && m_valid[j];
            es[k] = es[N-1] && above;
        end
        chk("m_kill", 64'(m_kill), 64'(flush));
        chk("m_stall", 64'(m_stall), 64'(es));
        chk("issue_stall", 64'(mul_issue_stall), 64'(es[N-1] && (m_valid == '1)));
        chk("alu_stall", 64'(alu_stall), 64'(areq && !ag));
        chk("inflight", 64'(mul_inflight), 64'($countones(m_valid)));

        exp_en = mg || ag;
        if (mg) begin
            exp_id = mul_rob_id; exp_val = mul_result; exp_src = 1;
        end else if (ag) begin
            exp_id = alu_wb_rob_id; exp_val = alu_wb_value; exp_src = 0;
        end
        if (flush || mg) begin
            losses = 0; mul_prio = 0;
        end else if (mreq) begin
            losses = (losses + 1 > LIM) ? LIM : losses + 1;
            if (losses == LIM) mul_prio = 1;
        end

        @(posedge clk);
        #1;
        chk("rob_wr_en", 64'(rob_wr_en), 64'(exp_en));
        if (exp_en) begin
            chk("rob_wr_id", 64'(rob_wr_id), 64'(exp_id));
            chk("rob_wr_value", 64'(rob_wr_value), 64'(exp_val));
            chk("rob_wr_src", 64'(rob_wr_src), 64'(exp_src));
        end
    endtask

    initial begin
        reset = 1'b0;
        drive(0, 5'b10110, 0, '0, '0, '0, '0);
        model_reset();
        #3;
        chk("rst_inflight", 64'(mul_inflight), 64'd3);
        chk("rst_m_stall", 64'(m_stall), 64'd0);
        @(posedge clk); #1;
        chk("rst_wr_en", 64'(rob_wr_en), 64'd0);
        chk("rst_wr_id", 64'(rob_wr_id), 64'd0);
        chk("rst_wr_value", 64'(rob_wr_value), 64'd0);
        chk("rst_wr_src", 64'(rob_wr_src), 64'd0);
        reset = 1'b1;

        // MUL only
        drive(0, 5'b10000, 0, 6'd9, 32'hdead, 6'd3, 32'h1234);
        #1;
        chk("mulonly_m_stall", 64'(m_stall), 64'd0);
        step();
        chk("mulonly_en", 64'(rob_wr_en), 64'd1);
        chk("mulonly_id", 64'(rob_wr_id), 64'd3);
        chk("mulonly_val", 64'(rob_wr_value), 64'h1234);
        chk("mulonly_src", 64'(rob_wr_src), 64'd1);

        // Conflict in ALU_PRIO; the stage-2 bubble's stall bit is don't-care
        drive(0, 5'b11011, 1, 6'd5, 32'haaaa, 6'd2, 32'hbbbb);
        #1;
        chk("conf_alu_stall", 64'(alu_stall), 64'd0);
        chk("conf_m_stall_valid", 64'(m_stall & m_valid), 64'b11000);
        chk("conf_issue", 64'(mul_issue_stall), 64'd0);
        step();
        chk("conf_src", 64'(rob_wr_src), 64'd0);
        chk("conf_id", 64'(rob_wr_id), 64'd5);

        // Flush clears the pending loss from the conflict above
        drive(1, 5'b10110, 1, 6'd7, 32'h7777, 6'd4, 32'h4444);
        #1;
        chk("flush_kill", 64'(m_kill), 64'd1);
        chk("flush_m_stall", 64'(m_stall), 64'd0);
        chk("flush_alu_stall", 64'(alu_stall), 64'd0);
        step();
        chk("flush_src", 64'(rob_wr_src), 64'd0);

        // Starvation: ALU x3, then MUL, then full pipe losing to ALU
        for (int i = 0; i < 4; i++) begin
            drive(0, 5'b10001, 1, 6'(10 + i), 32'(100 + i), 6'd20, 32'h2020);
            #1;
            chk("starve_alu_stall", 64'(alu_stall), 64'(i == 3));
            step();
            chk("starve_src", 64'(rob_wr_src), 64'(i == 3));
        end
        drive(0, 5'b11111, 1, 6'd30, 32'h3030, 6'd21, 32'h2121);
        #1;
        chk("full_m_stall", 64'(m_stall), 64'b11111);
        chk("full_issue", 64'(mul_issue_stall), 64'd1);
        chk("full_alu_stall", 64'(alu_stall), 64'd0);
        step();

        // Two more losses reach MUL_PRIO with an ALU write pending, then reset mid-cycle
        for (int i = 0; i < 2; i++) begin
            drive(0, 5'b10000, 1, 6'(40 + i), 32'(400 + i), 6'd22, 32'h2222);
            step();
        end
        #2;
        reset = 1'b0;
        #1;
        chk("async_wr_en", 64'(rob_wr_en), 64'd0);
        chk("async_wr_id", 64'(rob_wr_id), 64'd0);
        chk("async_wr_value", 64'(rob_wr_value), 64'd0);
        chk("async_wr_src", 64'(rob_wr_src), 64'd0);
        model_reset();
        @(posedge clk); #1;
        reset = 1'b1;
        drive(0, 5'b10000, 1, 6'd50, 32'h5050, 6'd23, 32'h2323);
        #1;
        chk("post_rst_alu_stall", 64'(alu_stall), 64'd0);
        step();
        chk("post_rst_src", 64'(rob_wr_src), 64'd0);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            drive(($urandom_range(7) == 0), N'($urandom), ($urandom_range(3) != 0),
                  R'($urandom), $urandom, R'($urandom), $urandom);
            step();
        end

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end

endmodule
